// File: rtl/cm_lat_buf_if.sv
// Bus bundle for cm_lat_buf: credit/issue toward the launcher, pipe arrival side,
// and the valid/ready output side. The buffer takes the slave modport.
interface cm_lat_buf_if #(
    parameter int unsigned DEPTH = 4,
    parameter type DTYPE = logic [7:0]
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic          i_issue;
    logic          o_credit;
    logic          i_valid;
    DTYPE          i_data;
    logic          o_valid;
    DTYPE          o_data;
    logic          i_ready;
    logic [LW-1:0] o_level;
    logic          o_err;

    modport slave (
        input  i_issue, i_valid, i_data, i_ready,
        output o_credit, o_valid, o_data, o_level, o_err
    );

    modport master (
        output i_issue, i_valid, i_data, i_ready,
        input  o_credit, o_valid, o_data, o_level, o_err
    );
endinterface

// File: rtl/cm_lat_buf.sv
// Credit-controlled elastic buffer catching the output of a non-stallable delay line.
// Define CM_LAT_BUF_ERR_EN to build the sticky protocol-error flag and its assertion.
module cm_lat_buf #(
    parameter int unsigned DEPTH = 4,
    parameter type DTYPE = logic [7:0]
) (
    input logic          i_clk,
    input logic          i_rst,
    cm_lat_buf_if.slave  bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    DTYPE          mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] credits_q, credits_d;
    logic          push, pop, issue_ok;

    always_comb begin
        push     = bus.i_valid && (level_q != FULL);
        pop      = (level_q != '0) && bus.i_ready;
        // An issue with no credit left is ignored so the counter cannot underflow.
        issue_ok = bus.i_issue && (credits_q != '0);

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        end

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end

        // Credits come back on pop, so every in-flight item owns a slot on arrival.
        credits_d = credits_q;
        if (issue_ok && !pop) begin
            credits_d = credits_q - LW'(1);
        end else if (!issue_ok && pop) begin
            credits_d = credits_q + LW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            credits_q <= FULL;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.i_data;
        end
    end

    always_comb begin
        bus.o_valid  = (level_q != '0);
        bus.o_data   = mem[rd_ptr_q];
        bus.o_credit = (credits_q != '0);
        bus.o_level  = level_q;
    end

`ifdef CM_LAT_BUF_ERR_EN
    logic err_q, bad_issue, bad_valid;

    always_comb begin
        bad_issue = bus.i_issue && (credits_q == '0);
        bad_valid = bus.i_valid && (level_q == FULL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (bad_issue || bad_valid) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;

    assert property (@(posedge i_clk) disable iff (i_rst) !(bad_issue || bad_valid))
        else $warning("cm_lat_buf: protocol violation (issue=%0b valid=%0b) at %0t",
                      bad_issue, bad_valid, $time);
`else
    assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_cm_lat_buf.sv
// Scoreboard bench for cm_lat_buf: DEPTH=4 and DEPTH=3 instances, each fed by a
// latency-2 valid/data delay line whose stages all reset.
module tb_cm_lat_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

`ifdef CM_LAT_BUF_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    cm_lat_buf_if #(.DEPTH(4), .DTYPE(logic [7:0])) bus4 ();
    cm_lat_buf_if #(.DEPTH(3), .DTYPE(logic [7:0])) bus3 ();

    cm_lat_buf #(.DEPTH(4), .DTYPE(logic [7:0])) u_dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));
    cm_lat_buf #(.DEPTH(3), .DTYPE(logic [7:0])) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));

    // Upstream launch + delay-line model.
    logic       launch4 = 0, launch3 = 0, force4 = 0;
    logic [7:0] ldata4 = 0, ldata3 = 0;
    logic [1:0] pv4, pv3;
    logic [7:0] pd4 [2];
    logic [7:0] pd3 [2];

    always @(posedge clk) begin
        if (rst) begin
            pv4 <= '0;
            pv3 <= '0;
        end else begin
            pv4 <= {pv4[0], launch4};
            pv3 <= {pv3[0], launch3};
        end
        pd4[1] <= pd4[0];
        pd4[0] <= ldata4;
        pd3[1] <= pd3[0];
        pd3[0] <= ldata3;
    end

    assign bus4.i_valid = pv4[1] | force4;
    assign bus4.i_data  = force4 ? 8'hEE : pd4[1];
    assign bus3.i_valid = pv3[1];
    assign bus3.i_data  = pd3[1];

    logic [7:0] exp4[$];
    logic [7:0] exp3[$];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop expected item whenever the DUT hands one over.
    always @(negedge clk) begin
        if (!rst && bus4.o_valid && bus4.i_ready) begin
            if (exp4.size() == 0) begin
                chk("pop4_unexpected", int'(bus4.o_data), -1);
            end else begin
                chk("pop4_data", int'(bus4.o_data), int'(exp4.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus3.o_level > 3) chk("level3_max", int'(bus3.o_level), 3);
            if (bus3.o_valid && bus3.i_ready) begin
                if (exp3.size() == 0) begin
                    chk("pop3_unexpected", int'(bus3.o_data), -1);
                end else begin
                    chk("pop3_data", int'(bus3.o_data), int'(exp3.pop_front()));
                end
            end
        end
    end

    task automatic drain4(input string name);
        int n = 0;
        while (exp4.size() != 0 && n < 40) begin
            step();
            n++;
        end
        if (exp4.size() != 0) chk({name, "_timeout"}, exp4.size(), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus4.i_issue = 0;
        bus4.i_ready = 0;
        bus3.i_issue = 0;
        bus3.i_ready = 0;
        rst = 1;
        step();
        step();
        rst = 0;
        step();

        // Reset state.
        chk("rst_credit", bus4.o_credit, 1);
        chk("rst_valid", bus4.o_valid, 0);
        chk("rst_level", bus4.o_level, 0);
        chk("rst_err", bus4.o_err, 0);

        // Fill with downstream stalled: exactly four credits.
        for (int i = 0; i < 4; i++) begin
            chk("fill_credit", bus4.o_credit, 1);
            bus4.i_issue = 1;
            launch4 = 1;
            ldata4 = 8'(i + 1);
            exp4.push_back(8'(i + 1));
            step();
        end
        bus4.i_issue = 0;
        launch4 = 0;
        chk("fill_credit_zero", bus4.o_credit, 0);
        step();
        step();
        chk("fill_level", bus4.o_level, 4);

        // Illegal issue must not wrap the counter.
        bus4.i_issue = 1;
        step();
        bus4.i_issue = 0;
        chk("illegal_issue_credit", bus4.o_credit, 0);

        // Illegal arrival into a full buffer is dropped.
        force4 = 1;
        step();
        force4 = 0;
        chk("drop_level", bus4.o_level, 4);
        chk("drop_err", bus4.o_err, int'(EXP_ERR));
        step();
        chk("drop_err_sticky", bus4.o_err, int'(EXP_ERR));

        // Release downstream: credit returns one cycle after first pop.
        bus4.i_ready = 1;
        step();
        chk("first_pop_credit", bus4.o_credit, 1);
        chk("first_pop_level", bus4.o_level, 3);
        drain4("drain_full");
        chk("drained_level", bus4.o_level, 0);
        chk("drained_err", bus4.o_err, int'(EXP_ERR));
        rst = 1;
        step();
        rst = 0;
        chk("err_cleared", bus4.o_err, 0);

        // Streaming 20 items back to back with latency-2 pipe.
        bus4.i_ready = 1;
        for (int i = 0; i < 20; i++) begin
            chk("stream_credit", bus4.o_credit, 1);
            if (i >= 3) chk("stream_valid", bus4.o_valid, 1);
            bus4.i_issue = 1;
            launch4 = 1;
            ldata4 = 8'(i);
            exp4.push_back(8'(i));
            step();
        end
        bus4.i_issue = 0;
        launch4 = 0;
        drain4("drain_stream");
        chk("stream_end_level", bus4.o_level, 0);

        // Reset mid-operation with level 2 and one item in flight.
        bus4.i_ready = 0;
        for (int i = 0; i < 3; i++) begin
            bus4.i_issue = 1;
            launch4 = 1;
            ldata4 = 8'(8'h40 + i);
            exp4.push_back(8'(8'h40 + i));
            step();
        end
        bus4.i_issue = 0;
        launch4 = 0;
        step();
        chk("pre_rst_level", bus4.o_level, 2);
        rst = 1;
        exp4.delete();
        step();
        rst = 0;
        chk("post_rst_valid", bus4.o_valid, 0);
        chk("post_rst_level", bus4.o_level, 0);
        chk("post_rst_credit", bus4.o_credit, 1);
        bus4.i_ready = 1;
        for (int i = 0; i < 5; i++) step();
        chk("no_stale_valid", bus4.o_valid, 0);

        // DEPTH=3 wrap-around with toggling ready.
        begin
            int sent = 0;
            int cyc = 0;
            while ((sent < 10 || exp3.size() != 0) && cyc < 300) begin
                bus3.i_ready = (cyc % 2 == 0);
                if (sent < 10 && bus3.o_credit) begin
                    bus3.i_issue = 1;
                    launch3 = 1;
                    ldata3 = 8'(8'h80 + sent);
                    exp3.push_back(8'(8'h80 + sent));
                    sent++;
                end else begin
                    bus3.i_issue = 0;
                    launch3 = 0;
                end
                step();
                cyc++;
            end
            bus3.i_issue = 0;
            launch3 = 0;
            if (exp3.size() != 0 || sent != 10) chk("wrap_timeout", sent, 10);
            bus3.i_ready = 1;
            step();
            step();
            chk("wrap_end_level", bus3.o_level, 0);
            chk("wrap_end_credit", bus3.o_credit, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cm_lat_buf.md
Name: cm_lat_buf

Overview:
- Credit-controlled elastic buffer that sits directly downstream of a fixed-latency, non-stallable delay line (cm_shr or any pipeline without backpressure).
- Catches every item emerging from the pipe and re-presents it on a valid/ready interface.
- Issues credits to the upstream launcher, so items are only launched into the pipe when buffer space is guaranteed on arrival.
- Absorbs downstream stalls without data loss.

Parameters:
- DEPTH, 4, buffer entries and initial credit count; legal range >= 1; any value (not restricted to powers of two). Full throughput requires DEPTH >= pipe latency + 1.
- DTYPE, logic [7 : 0], payload type.

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_issue  input  1  upstream launched one item into the pipe this cycle (consumes one credit)
- o_credit  output  1  at least one credit available; upstream may assert i_issue
- i_valid  input  1  pipe output carries an item this cycle (no backpressure possible)
- i_data  input  DTYPE  pipe output payload
- o_valid  output  1  buffer head valid
- o_data  output  DTYPE  buffer head payload
- i_ready  input  1  downstream accepts head when o_valid=1
- o_level  output  $clog2(DEPTH+1)  current occupancy
- o_err  output  1  sticky protocol-error flag (see Optional Feature)

Behaviour:
- Storage: DEPTH x DTYPE array, write pointer, read pointer, occupancy counter.
- Pointer width $clog2(DEPTH), minimum 1. Pointers wrap explicitly from DEPTH-1 to 0.
- Push: i_valid=1 and level < DEPTH. Writes i_data at wr_ptr, advances wr_ptr.
- Pop: o_valid=1 and i_ready=1. Advances rd_ptr.
- Level update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop while full is not possible, because a push requires level < DEPTH. Under the credit contract level never exceeds DEPTH.
- Empty buffer: push and pop in the same cycle is impossible, since o_valid=0.
- o_valid = (level != 0). o_data = mem[rd_ptr], read combinationally.
- o_data is don't-care while o_valid=0; the bench must not check it.
- Latency: item pushed in cycle N gives o_valid=1 in cycle N+1. No combinational path from i_valid to o_valid, or from i_data to o_data.
- Throughput: one push and one pop per cycle, sustained.
- Credit counter: width $clog2(DEPTH+1); reset value DEPTH.
  - Decrement on i_issue only.
  - Increment on pop only.
  - Unchanged on both or neither.
  - o_credit = (credits != 0), registered-state derived.
- Credit is returned on pop, not on push. This guarantees a slot for every in-flight item, regardless of pipe latency.
- Illegal i_issue (credits == 0): counter holds at 0 (no underflow).
- Illegal i_valid (level == DEPTH): item dropped, no pointer or level change.
- Reset values:
  - level 0, pointers 0, credits DEPTH
  - o_valid 0, o_credit 1, o_level 0, o_err 0
  - Memory contents not reset.
- Reset mid-operation: buffered items are discarded and credits reload to DEPTH on the next edge. i_issue and i_valid in the reset cycle are ignored.
- System rule: the valid delay line feeding i_valid must reset all stages (SHR_RST_ALL). Otherwise stale in-flight valids arrive after reset and consume slots without credits.
- Downstream may drop i_ready at any time. o_valid/o_data hold stable until popped.

Optional Feature:
- Macro: CM_LAT_BUF_ERR_EN.
- With the macro defined:
  - o_err is a sticky register, set in the cycle after an illegal i_issue (credits==0) or an illegal i_valid (level==DEPTH).
  - o_err is cleared only by i_rst.
  - A simulation-only assertion reports each violation with the cycle time.
- Without the macro:
  - o_err is tied to 0 and no detection logic is built.
  - Illegal events are still handled as above (hold/drop).

Test Plan:
- Reset then idle -> o_credit=1, o_valid=0, o_level=0; credits observed as 4 after 4 consecutive i_issue (o_credit=0 after 4th).
- DEPTH=4, pipe latency 2, i_ready=1, issue every cycle for 20 cycles, data 0..19 -> o_valid continuous from cycle 3, o_data 0..19 in order, o_credit never deasserts.
- i_ready=0, issue until o_credit=0 -> exactly 4 issued, o_level reaches 4; raise i_ready -> data drains 4 items in order, o_credit reasserts one cycle after first pop.
- Wrap-around with DEPTH=3: push/pop 10 items with i_ready toggling 1,0,1,0 -> order preserved, pointers wrap past 2, o_level never >3.
- Reset asserted with o_level=2, credits=1 -> next cycle o_valid=0, o_level=0, o_credit=1 (credits 4); no stale item emerges afterwards (valid line reset with all stages).
- With CM_LAT_BUF_ERR_EN: force i_valid while o_level=4 -> item dropped, o_level stays 4, o_err=1 next cycle and stays 1 until i_rst; without the macro -> same drop, o_err stays 0.
